// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int N_DEF = 8;
  localparam int M_DEF = 2 * N_DEF + 1;
  localparam int CNT_W = $clog2(M_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle between a requester and the divider.
interface seq_restoring_divider_if #(
  parameter int N = 8,
  parameter int M = 2 * N + 1
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r,
  input  logic         dbit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         qbit
);
  logic [N:0] r_shift;
  logic [N:0] trial;

  // r stays below divisor, so r_shift < 2*divisor and trial[N] is a clean borrow flag
  assign r_shift = {r[N-1:0], dbit};
  assign trial   = r_shift - {1'b0, divisor};
  assign qbit    = ~trial[N];
  assign r_next  = qbit ? trial : r_shift;
endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned M/N-bit divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = 2 * N + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = $clog2(M);

  state_t        state_reg, state_next;
  logic [M-1:0]  dividend_sh;
  logic [N-1:0]  divisor_reg;
  logic [N:0]    r_reg;
  logic [N:0]    r_next;
  logic          qbit;
  logic [CW-1:0] count_reg;
  logic [M-1:0]  quotient_reg;
  logic [N-1:0]  remainder_reg;
  logic          dbz_reg;
  logic          accept;
  logic          last_step;
  logic          zero_div;

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign zero_div  = (bus.divisor == '0);
  assign last_step = (count_reg == CW'(M - 1));

  div_step #(.N(N)) u_step (
    .r       (r_reg),
    .dbit    (dividend_sh[M-1]),
    .divisor (divisor_reg),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = zero_div ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_sh   <= '0;
      divisor_reg   <= '0;
      r_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient_reg  <= '1;
        remainder_reg <= bus.dividend[N-1:0];
        dbz_reg       <= 1'b1;
      end else begin
        dividend_sh <= bus.dividend;
        divisor_reg <= bus.divisor;
        r_reg       <= '0;
        count_reg   <= '0;
        dbz_reg     <= 1'b0;
      end
    end else if (state_reg == RUN) begin
      // quotient doubles as the result shift register; it is fully refilled after M steps
      r_reg        <= r_next;
      dividend_sh  <= {dividend_sh[M-2:0], 1'b0};
      quotient_reg <= {quotient_reg[M-2:0], qbit};
      count_reg    <= count_reg + CW'(1);
      if (last_step) remainder_reg <= r_next[N-1:0];
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised checks of the restoring divider against hand values and floor/mod.
module tb_seq_restoring_divider;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  seq_restoring_divider_if #(.N(8)) bus ();

  seq_restoring_divider #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Runs one operation starting just after a rising edge with the block idle.
  task automatic run_op(input logic [16:0] a, input logic [7:0] b, input int hold, input bit noise,
                        output logic [16:0] q, output logic [7:0] r, output logic z, output int lat,
                        output bit run_ok, output bit stable_ok, output bit idle_ok);
    run_ok = 1'b1; stable_ok = 1'b1; idle_ok = 1'b1;
    bus.dividend = a; bus.divisor = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) run_ok = 1'b0;
      if (noise) begin
        bus.in_valid = lat[0]; bus.dividend = 17'd999; bus.divisor = 8'd3;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    if (!bus.out_valid) begin
      lat = -1; stable_ok = 1'b0; idle_ok = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        bus.in_valid = ~i[0]; bus.dividend = 17'd999; bus.divisor = 8'd3;
      end
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.quotient !== q || bus.remainder !== r ||
          bus.div_by_zero !== z) stable_ok = 1'b0;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (bus.out_valid || !bus.in_ready) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 17'd0 ||
        bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0)
      $display("FAIL reset_state: rdy=%b vld=%b q=%0d r=%0d z=%b, need rdy=1 vld=0 q=0 r=0 z=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_basic();
    logic [16:0] q; logic [7:0] r; logic z; int lat; bit ro, so, io;
    run_op(17'd100, 8'd7, 0, 1'b0, q, r, z, lat, ro, so, io);
    $display("op 100/7: q=%0d r=%0d z=%b lat=%0d", q, r, z, lat);
    total_cnt++; if (q !== 17'd14) $display("FAIL basic_q: got %0d need 14", q); else pass_cnt++;
    total_cnt++; if (r !== 8'd2) $display("FAIL basic_r: got %0d need 2", r); else pass_cnt++;
    total_cnt++; if (z !== 1'b0) $display("FAIL basic_z: got %b need 0", z); else pass_cnt++;
    total_cnt++; if (lat != 17) $display("FAIL basic_latency: got %0d need 17", lat); else pass_cnt++;
    total_cnt++; if (!ro) $display("FAIL basic_run_ready: in_ready got 1 during RUN need 0"); else pass_cnt++;
    total_cnt++; if (!io) $display("FAIL basic_idle: after handshake need out_valid=0 in_ready=1"); else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [16:0] va [3] = '{17'd65025, 17'd131071, 17'd5};
    logic [7:0]  vb [3] = '{8'd255, 8'd1, 8'd200};
    logic [16:0] eq [3] = '{17'd255, 17'd131071, 17'd0};
    logic [7:0]  er [3] = '{8'd0, 8'd0, 8'd5};
    logic [16:0] q; logic [7:0] r; logic z; int lat; bit ro, so, io;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 0, 1'b0, q, r, z, lat, ro, so, io);
      $display("op %0d/%0d: q=%0d r=%0d z=%b lat=%0d", va[i], vb[i], q, r, z, lat);
      total_cnt++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat != 17)
        $display("FAIL vector_%0d: q=%0d r=%0d z=%b lat=%0d, need q=%0d r=%0d z=0 lat=17",
                 i, q, r, z, lat, eq[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic [16:0] q; logic [7:0] r; logic z; int lat; bit ro, so, io;
    run_op(17'd1234, 8'd0, 0, 1'b0, q, r, z, lat, ro, so, io);
    $display("op 1234/0: q=%h r=%h z=%b lat=%0d", q, r, z, lat);
    total_cnt++;
    if (q !== 17'h1FFFF || r !== 8'hD2 || z !== 1'b1)
      $display("FAIL div_zero_result: q=%h r=%h z=%b, need q=1ffff r=d2 z=1", q, r, z);
    else pass_cnt++;
    // out_valid already high right after the accept edge
    total_cnt++; if (lat != 0) $display("FAIL div_zero_latency: extra edges %0d need 0", lat); else pass_cnt++;
    run_op(17'd100, 8'd7, 0, 1'b0, q, r, z, lat, ro, so, io);
    $display("op 100/7 after zero: q=%0d r=%0d z=%b", q, r, z);
    total_cnt++;
    if (q !== 17'd14 || r !== 8'd2 || z !== 1'b0)
      $display("FAIL div_zero_clear: q=%0d r=%0d z=%b, need q=14 r=2 z=0", q, r, z);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [16:0] q; logic [7:0] r; logic z; int lat; bit ro, so, io;
    run_op(17'd100, 8'd7, 5, 1'b1, q, r, z, lat, ro, so, io);
    $display("backpressure 100/7: q=%0d r=%0d lat=%0d stable=%b idle=%b", q, r, lat, so, io);
    total_cnt++;
    if (q !== 17'd14 || r !== 8'd2 || lat != 17)
      $display("FAIL bp_result: q=%0d r=%0d lat=%0d, need q=14 r=2 lat=17", q, r, lat);
    else pass_cnt++;
    total_cnt++; if (!ro) $display("FAIL bp_run_ready: in_ready got 1 during RUN need 0"); else pass_cnt++;
    total_cnt++; if (!so) $display("FAIL bp_hold: outputs changed during hold, need stable"); else pass_cnt++;
    total_cnt++; if (!io) $display("FAIL bp_release: after handshake need out_valid=0 in_ready=1"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [16:0] q; logic [7:0] r; logic z; int lat; bit ro, so, io;
    bus.dividend = 17'd60000; bus.divisor = 8'd13; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("mid-run reset: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_mid: out_valid=%b in_ready=%b, need 0 and 1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(17'd60000, 8'd13, 0, 1'b0, q, r, z, lat, ro, so, io);
    $display("op 60000/13: q=%0d r=%0d lat=%0d", q, r, lat);
    total_cnt++;
    if (q !== 17'd4615 || r !== 8'd5 || z !== 1'b0 || lat != 17)
      $display("FAIL reset_mid_next: q=%0d r=%0d z=%b lat=%0d, need q=4615 r=5 z=0 lat=17", q, r, z, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [16:0] a, q, eq; logic [7:0] b, r, er; logic z, ez; int lat; bit ro, so, io;
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      a = 17'($urandom);
      b = ($urandom_range(0, 99) < 5) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) begin
        eq = 17'h1FFFF; er = a[7:0]; ez = 1'b1;
      end else begin
        eq = a / {9'd0, b}; er = 8'(a % {9'd0, b}); ez = 1'b0;
      end
      run_op(a, b, $urandom_range(0, 2), 1'b0, q, r, z, lat, ro, so, io);
      $display("rand %0d: %0d/%0d q=%0d r=%0d z=%b", n, a, b, q, r, z);
      total_cnt++;
      if (q !== eq || r !== er || z !== ez || !so || !io) begin
        $display("FAIL rand_%0d: %0d/%0d q=%0d r=%0d z=%b, need q=%0d r=%0d z=%b", n, a, b, q, r, z, eq, er, ez);
        bad++;
        if (bad > 10) return;
      end else pass_cnt++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
